// File: rtl/nfc_pkg.sv
// Shared definitions for the NFC command dispatcher: command field layout,
// sizing constants, FSM state encoding and the push legality check.
package nfc_pkg;

  localparam int unsigned CMD_W     = 33;
  localparam int unsigned MEM_DEPTH = 128;

  localparam int unsigned CMD_RD_BIT  = 32;
  localparam int unsigned CMD_FA_MSB  = 31;
  localparam int unsigned CMD_FA_LSB  = 14;
  localparam int unsigned CMD_MA_MSB  = 13;
  localparam int unsigned CMD_MA_LSB  = 7;
  localparam int unsigned CMD_LEN_MSB = 6;
  localparam int unsigned CMD_LEN_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_RUN  = 2'd2
  } nfc_state_e;

  // A transfer is legal when it moves at least one word and stays inside
  // the memory window; the sum is formed in 8 bits so it cannot overflow.
  function automatic logic cmd_legal(input logic [6:0] mem_addr,
                                     input logic [6:0] len);
    logic [7:0] end_addr;
    end_addr = {1'b0, mem_addr} + {1'b0, len};
    return (len != 7'd0) && (end_addr <= 8'(MEM_DEPTH));
  endfunction

endpackage

// File: rtl/nfc_cmd_fifo.sv
// Synchronous FIFO holding queued NFC commands. Head entry is visible
// combinationally on rd_data_o; writes to a full FIFO and reads from an
// empty FIFO are ignored.
module nfc_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         rd_en_i,
  output logic [W-1:0] rd_data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic          do_wr, do_rd;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign rd_data_o = mem_q[rd_ptr_q];
  assign do_wr     = wr_en_i && !full_o;
  assign do_rd     = rd_en_i && !empty_o;

  // Next pointer and occupancy values; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since occupancy gates reads.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/nfc_cmd_dispatch.sv
// Queues legal commands and hands them to the NFC one at a time, using the
// NFC done handshake, with a per-operation timeout watchdog.
module nfc_cmd_dispatch
  import nfc_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CMD_W-1:0] in_cmd,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [CMD_W-1:0] cmd,
  input  logic             done,
  output logic             busy,
  output logic [7:0]       issued_cnt,
  output logic             reject,
  output logic             timeout
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  nfc_state_e       state_q, state_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic [7:0]       issued_q, issued_d;
  logic [CW-1:0]    cyc_q, cyc_d;
  logic             timeout_q, timeout_d;
  logic             reject_q;

  logic             push, legal, pop;
  logic             fifo_full, fifo_empty;
  logic [CMD_W-1:0] fifo_head;

  assign in_ready   = !fifo_full;
  assign push       = in_valid && in_ready;
  assign legal      = cmd_legal(in_cmd[CMD_MA_MSB:CMD_MA_LSB],
                                in_cmd[CMD_LEN_MSB:CMD_LEN_LSB]);
  assign cmd        = cmd_q;
  assign issued_cnt = issued_q;
  assign reject     = reject_q;
  assign timeout    = timeout_q;
  assign busy       = (state_q != ST_IDLE) || !fifo_empty;

  nfc_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (CMD_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (push && legal),
    .wr_data_i (in_cmd),
    .rd_en_i   (pop),
    .rd_data_o (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Handshake FSM next-state; cyc_q holds cycles already elapsed, so the
  // current cycle is the TIMEOUT-th one when cyc_q == TIMEOUT-1.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    issued_d  = issued_q;
    cyc_d     = cyc_q;
    timeout_d = timeout_q;
    pop       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (done && !fifo_empty) begin
          state_d  = ST_ACK;
          pop      = 1'b1;
          cmd_d    = fifo_head;
          issued_d = issued_q + 8'd1;
          cyc_d    = '0;
        end
      end
      ST_ACK, ST_RUN: begin
        if (cyc_q == CW'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cyc_d = cyc_q + CW'(1);
          if (state_q == ST_ACK && !done) state_d = ST_RUN;
          if (state_q == ST_RUN &&  done) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, issued command, counters and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cmd_q     <= '0;
      issued_q  <= '0;
      cyc_q     <= '0;
      timeout_q <= 1'b0;
      reject_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      issued_q  <= issued_d;
      cyc_q     <= cyc_d;
      timeout_q <= timeout_d;
      reject_q  <= push && !legal;
    end
  end

endmodule

// File: doc/nfc_cmd_dispatch.md
NFC_CMD_DISPATCH -- requirements
Module: nfc_cmd_dispatch

Interface
REQ-001 Parameter DEPTH, default 4: command FIFO depth; power of two, at least 2.
REQ-002 Parameter TIMEOUT, default 1000: maximum cycles allowed for one NFC operation.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 in_cmd  in  33  command: [32] 1=read flash->mem, 0=write mem->flash; [31:14] flash address; [13:7] memory address; [6:0] length.
REQ-006 in_valid  in  1  in_cmd is valid this cycle.
REQ-007 in_ready  out  1  FIFO can accept; equals !full.
REQ-008 cmd  out  33  command presented to the NFC cmd input; registered.
REQ-009 done  in  1  NFC done; high means the NFC is idle and samples cmd.
REQ-010 busy  out  1  high while a command is outstanding or the FIFO is non-empty.
REQ-011 issued_cnt  out  8  count of commands issued to the NFC; wraps at 255->0.
REQ-012 reject  out  1  one-cycle pulse when an accepted push is discarded as illegal.
REQ-013 timeout  out  1  sticky flag; set when the NFC exceeds TIMEOUT cycles.

Function
REQ-014 Push occurs when in_valid && in_ready.
REQ-015 Legal push: length != 0 and memory address + length <= 128, evaluated in 8-bit arithmetic. Only legal pushes are written to the FIFO.
REQ-016 Illegal push: in_ready still applies, the command is dropped, and reject pulses in the following cycle.
REQ-017 Push on a full FIFO is ignored; no overwrite and no reject.
REQ-018 FSM states: IDLE, ACK, RUN.
REQ-019 IDLE -> ACK when done=1 and the FIFO is non-empty, on the same edge: pop the head into cmd and increment issued_cnt.
REQ-020 ACK -> RUN on the first cycle with done=0.
REQ-021 RUN -> IDLE on the first cycle with done=1. Back-to-back issue can occur on the next edge.
REQ-022 Cycle counter clears on entry to ACK and counts in ACK and RUN. At count == TIMEOUT: set timeout, return to IDLE, and leave cmd unchanged.
REQ-023 cmd holds its last issued value between commands; it never changes outside the IDLE->ACK transition.
REQ-024 Simultaneous push and pop on a full FIFO: pop happens and push is refused, because in_ready reflects the pre-edge full state.
REQ-025 Simultaneous push and pop on an empty FIFO: no pop; the push is stored.
REQ-026 FIFO pointers wrap modulo DEPTH; the count is kept separately, width log2(DEPTH)+1.
REQ-027 busy = (state != IDLE) || !empty.

Reset
REQ-028 On rst, the following SHALL be cleared, even mid-operation: state=IDLE, FIFO empty, cmd=33'h0, issued_cnt=0, reject=0, timeout=0, cycle counter=0. Any outstanding command is abandoned.
REQ-029 in_ready SHALL read 1 in the first cycle after rst deasserts.

Structure
REQ-030 Shared package nfc_pkg SHALL hold:
- field positions for cmd bits 32, 31:14, 13:7 and 6:0;
- CMD_W=33 and MEM_DEPTH=128;
- an enum for the FSM states.
REQ-031 The storage SHALL be one sub-module, nfc_cmd_fifo, a synchronous FIFO with its own count, full and empty flags.
REQ-032 Total RTL SHALL be about 150-250 lines.

Verification
REQ-033 Reset, then push {1, 18'h00010, 7'h00, 7'd64} with done=1 -> cmd equals the pushed value 2 cycles after push; issued_cnt=1; state ACK.
REQ-034 Push 3 commands while done is held low -> none issue. Then a done 0->1->0->1 sequence from the NFC model -> the commands issue in FIFO order; issued_cnt=3; busy falls after the last done rise.
REQ-035 Push length 0, then memory address 7'h70 with length 7'd32 -> reject pulses twice; FIFO stays empty; issued_cnt=0.
REQ-036 Fill DEPTH=4 -> in_ready=0. A 5th push is ignored. Pop one -> in_ready=1 the next cycle.
REQ-037 Issue a command, then hold done=0 for 1000 cycles -> timeout=1 at cycle 1000; state IDLE; next queued command issues on the next done=1.
REQ-038 Assert rst while in RUN with 2 queued commands -> all outputs read reset values the next cycle; no further issue without a new push.
